// File: rtl/score_keeper_if.sv
// score_keeper_if: judgement pulses in, score/streak/multiplier and BCD snapshot out.
// master drives the event pulses, slave is the score keeper itself.
interface score_keeper_if;
  logic        hit_pulse;
  logic        miss_pulse;
  logic        frame_start;
  logic [16:0] score;
  logic [2:0]  multiplier;
  logic [7:0]  streak;
  logic [19:0] digits;
  logic        digits_valid;
  logic        busy;

  modport master (
    output hit_pulse, miss_pulse, frame_start,
    input  score, multiplier, streak,
    input  digits, digits_valid, busy
  );

  modport slave (
    input  hit_pulse, miss_pulse, frame_start,
    output score, multiplier, streak,
    output digits, digits_valid, busy
  );
endinterface

// File: rtl/score_keeper.sv
// score_keeper: hit/miss score accumulator with a per-frame double-dabble BCD snapshot.
// SCORE_MULTIPLIER_EN adds the streak-driven points multiplier.
module score_keeper #(
  parameter int HIT_POINTS  = 10,
  parameter int MAX_SCORE   = 99999,
  parameter int STREAK_STEP = 10,
  parameter int MAX_MULT    = 4
) (
  input logic           clk,
  input logic           reset,
  score_keeper_if.slave sk
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [16:0] score_q;
  logic [7:0]  streak_q;
  logic [2:0]  mult;
  logic [17:0] sum;
  logic [16:0] score_nx;
  logic        hit;

  assign hit = sk.hit_pulse & ~sk.miss_pulse;

  // Sum is one bit wider than score so the saturation compare cannot wrap.
  assign score_nx = (sum > 18'(MAX_SCORE)) ? 17'(MAX_SCORE)
                                           : sum[16:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q  <= '0;
      streak_q <= '0;
    end else if (sk.miss_pulse) begin
      streak_q <= '0;
    end else if (hit) begin
      score_q <= score_nx;
      if (streak_q != 8'hff)
        streak_q <= streak_q + 8'd1;
    end
  end

`ifdef SCORE_MULTIPLIER_EN
  localparam int SW = $clog2(STREAK_STEP + 1);

  logic [SW-1:0] step_q;
  logic [2:0]    mult_q;

  assign sum  = 18'(score_q) + 18'(HIT_POINTS) * 18'(mult_q);
  assign mult = mult_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q <= '0;
      mult_q <= 3'd1;
    end else if (sk.miss_pulse) begin
      step_q <= '0;
      mult_q <= 3'd1;
    end else if (hit) begin
      if (step_q == SW'(STREAK_STEP - 1)) begin
        step_q <= '0;
        if (mult_q < 3'(MAX_MULT))
          mult_q <= mult_q + 3'd1;
      end else begin
        step_q <= step_q + SW'(1);
      end
    end
  end
`else
  assign sum  = 18'(score_q) + 18'(HIT_POINTS);
  assign mult = 3'd1;
`endif

  state_t      st;
  logic [16:0] bin_q;
  logic [19:0] bcd_q;
  logic [19:0] bcd_adj;
  logic [4:0]  cnt_q;
  logic [19:0] digits_q;
  logic        valid_q;
  logic        busy_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 5; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st       <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (st)
        IDLE: begin
          if (sk.frame_start) begin
            bin_q  <= score_q;
            bcd_q  <= '0;
            cnt_q  <= 5'd17;
            busy_q <= 1'b1;
            st     <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd1)
            st <= DONE;
        end
        DONE: begin
          digits_q <= bcd_q;
          valid_q  <= 1'b1;
          busy_q   <= 1'b0;
          st       <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign sk.score        = score_q;
  assign sk.streak       = streak_q;
  assign sk.multiplier   = mult;
  assign sk.digits       = digits_q;
  assign sk.digits_valid = valid_q;
  assign sk.busy         = busy_q;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: directed checks of scoring, saturation and BCD snapshot timing.
// A second instance with MAX_SCORE=55 shares the same stimulus.
module tb_score_keeper;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hit = 1'b0;
  logic miss = 1'b0;
  logic fs = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

`ifdef SCORE_MULTIPLIER_EN
  localparam int M10 = 2;
  localparam int S11 = 120;
  localparam logic [31:0] D11 = 32'h00120;
`else
  localparam int M10 = 1;
  localparam int S11 = 110;
  localparam logic [31:0] D11 = 32'h00110;
`endif

  always #5 clk = ~clk;

  score_keeper_if i1 ();
  score_keeper_if i2 ();

  assign i1.hit_pulse   = hit;
  assign i1.miss_pulse  = miss;
  assign i1.frame_start = fs;
  assign i2.hit_pulse   = hit;
  assign i2.miss_pulse  = miss;
  assign i2.frame_start = fs;

  score_keeper u1 (
    .clk   (clk),
    .reset (reset),
    .sk    (i1)
  );

  score_keeper #(.MAX_SCORE(55)) u2 (
    .clk   (clk),
    .reset (reset),
    .sk    (i2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) hit = 1'b1;
      @(negedge clk) hit = 1'b0;
    end
  endtask

  // lat = posedges after the sampling edge until digits_valid is seen
  task automatic convert(input bit inject, input bit abort,
                         output int lat, output int pulses,
                         output logic busy1);
    lat = -1;
    pulses = 0;
    busy1 = 1'b0;
    @(negedge clk) fs = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        fs = 1'b0;
        busy1 = i1.busy;
      end
      if (i1.digits_valid) begin
        pulses++;
        if (lat < 0) lat = k - 1;
      end
      if (inject) begin
        if (k == 3) hit = 1'b1;
        if (k == 4) hit = 1'b0;
        if (k == 6) fs = 1'b1;
        if (k == 7) fs = 1'b0;
      end
      if (abort) begin
        if (k == 10) reset = 1'b1;
        if (k == 12) reset = 1'b0;
      end
    end
  endtask

  int lat;
  int pulses;
  logic b1;

  initial begin
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    check("rst_score", 32'(i1.score), 0);
    check("rst_mult", 32'(i1.multiplier), 1);
    check("rst_streak", 32'(i1.streak), 0);
    check("rst_digits", 32'(i1.digits), 0);
    check("rst_valid", 32'(i1.digits_valid), 0);
    check("rst_busy", 32'(i1.busy), 0);

    hits(3);
    check("h3_score", 32'(i1.score), 30);
    check("h3_streak", 32'(i1.streak), 3);
    check("h3_mult", 32'(i1.multiplier), 1);
    convert(1'b0, 1'b0, lat, pulses, b1);
    check("h3_busy", 32'(b1), 1);
    check("h3_lat", 32'(lat), 18);
    check("h3_pulses", 32'(pulses), 1);
    check("h3_digits", 32'(i1.digits), 32'h00030);
    check("h3_idle", 32'(i1.busy), 0);

    do_reset();
    hits(10);
    check("h10_mult", 32'(i1.multiplier), M10);
    check("h10_score", 32'(i1.score), 100);
    hits(1);
    check("h11_score", 32'(i1.score), S11);
    check("h11_streak", 32'(i1.streak), 11);
    convert(1'b0, 1'b0, lat, pulses, b1);
    check("h11_digits", 32'(i1.digits), D11);
    @(negedge clk) miss = 1'b1;
    @(negedge clk) miss = 1'b0;
    check("miss_mult", 32'(i1.multiplier), 1);
    check("miss_streak", 32'(i1.streak), 0);
    check("miss_score", 32'(i1.score), S11);

    do_reset();
    hits(5);
    check("s5_streak", 32'(i1.streak), 5);
    @(negedge clk) begin hit = 1'b1; miss = 1'b1; end
    @(negedge clk) begin hit = 1'b0; miss = 1'b0; end
    check("hm_score", 32'(i1.score), 50);
    check("hm_streak", 32'(i1.streak), 0);
    check("hm_mult", 32'(i1.multiplier), 1);

    do_reset();
    for (int i = 1; i <= 7; i++) begin
      hits(1);
      check($sformatf("sat_%0d", i), 32'(i2.score),
            (i < 6) ? 32'(10 * i) : 32'd55);
    end
    check("sat_streak", 32'(i2.streak), 7);
    convert(1'b0, 1'b0, lat, pulses, b1);
    check("sat_digits", 32'(i2.digits), 32'h00055);
    check("ref_digits", 32'(i1.digits), 32'h00070);

    do_reset();
    hits(2);
    convert(1'b1, 1'b0, lat, pulses, b1);
    check("busy_pulses", 32'(pulses), 1);
    check("busy_lat", 32'(lat), 18);
    check("busy_digits", 32'(i1.digits), 32'h00020);
    check("busy_score", 32'(i1.score), 30);

    convert(1'b0, 1'b1, lat, pulses, b1);
    check("abort_pulses", 32'(pulses), 0);
    check("abort_busy", 32'(i1.busy), 0);
    check("abort_digits", 32'(i1.digits), 0);
    check("abort_score", 32'(i1.score), 0);
    hits(4);
    convert(1'b0, 1'b0, lat, pulses, b1);
    check("post_lat", 32'(lat), 18);
    check("post_digits", 32'(i1.digits), 32'h00040);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
